// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output stage: resolution, channel count,
// the full-on duty code and the per-channel output mode decode.
package pwm_pkg;

    localparam int PWM_RES_BITS = 8;
    localparam int NUM_CH       = 16;
    localparam logic [PWM_RES_BITS-1:0] DUTY_FULL = 8'hFF;

    // What a single output pin is doing this cycle
    typedef enum logic [1:0] {
        OFF    = 2'd0,
        STATIC = 2'd1,
        PWM    = 2'd2
    } ch_mode_e;

    // Output enable dominates; PWM select only matters once the pin is enabled
    function automatic ch_mode_e ch_mode(input logic en_out, input logic en_pwm);
        if (!en_out) begin
            return OFF;
        end else if (!en_pwm) begin
            return STATIC;
        end else begin
            return PWM;
        end
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler for the PWM counter: presc runs 0..CLK_DIV-1 and tick is
// high on the last count. With CLK_DIV = 1 presc stays at 0 and tick is
// permanently high.
module pwm_prescaler #(
    parameter int CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc;

    // Free-running modulo-CLK_DIV counter
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (presc == LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = (presc == LAST);

endmodule

// File: rtl/pwm_output_stage.sv
// PWM generator and 16-channel output mux fed by the SPI register file.
// Each pin is forced low, held high, or driven with the shared PWM waveform.
// Optional build macro PWM_DUTY_SHADOW_EN: the duty byte is captured into a
// shadow register only at period boundaries, so mid-period writes never
// produce runt or stretched pulses. Without it the duty input is used live.
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              en_reg_out_7_0,
    input  logic [7:0]              en_reg_out_15_8,
    input  logic [7:0]              en_reg_pwm_7_0,
    input  logic [7:0]              en_reg_pwm_15_8,
    input  logic [PWM_RES_BITS-1:0] pwm_duty_cycle,
    output logic [NUM_CH-1:0]       out,
    output logic                    period_start
);

    logic                    tick;
    logic                    boundary;
    logic [PWM_RES_BITS-1:0] cnt;
    logic [PWM_RES_BITS-1:0] duty_act;
    logic                    pwm_sig;
    logic [NUM_CH-1:0]       en_out;
    logic [NUM_CH-1:0]       en_pwm;
    logic [NUM_CH-1:0]       out_nxt;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    // The edge that wraps cnt 255 -> 0 starts a new period
    assign boundary = tick && (cnt == '1);

    // PWM counter: steps once per prescaler tick, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef PWM_DUTY_SHADOW_EN
    logic [PWM_RES_BITS-1:0] duty_shadow;

    // Duty shadow: a write takes effect only when the next period begins
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_shadow <= '0;
        end else if (boundary) begin
            duty_shadow <= pwm_duty_cycle;
        end
    end

    assign duty_act = duty_shadow;
`else
    assign duty_act = pwm_duty_cycle;
`endif

    // Compare and per-channel mux; 0xFF is special-cased to stay high all period
    always_comb begin
        pwm_sig = (duty_act == DUTY_FULL) ? 1'b1 : (cnt < duty_act);
        out_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (ch_mode(en_out[i], en_pwm[i]))
                OFF:     out_nxt[i] = 1'b0;
                STATIC:  out_nxt[i] = 1'b1;
                PWM:     out_nxt[i] = pwm_sig;
                default: out_nxt[i] = 1'b0;
            endcase
        end
    end

    // Output registers and the period-start pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            out          <= out_nxt;
            period_start <= boundary;
        end
    end

endmodule

// File: tb/tb_pwm_output_stage.sv
// Self-checking bench for pwm_output_stage (CLK_DIV = 13). Expected values
// are queued when stimulus is applied and popped when the output is observed.
module tb_pwm_output_stage;

    localparam int CLK_DIV = 13;
    localparam int PERIOD  = 256 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  eo_lo = 8'hFF;
    logic [7:0]  eo_hi = 8'hFF;
    logic [7:0]  ep_lo = 8'hFF;
    logic [7:0]  ep_hi = 8'hFF;
    logic [7:0]  duty  = 8'hFF;
    logic [15:0] out;
    logic        period_start;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    pwm_output_stage #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (period_start)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    // Checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic observe(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %0d, want <nothing queued>", tag, obs);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    // Driver tasks
    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        eo_lo = eo[7:0];
        eo_hi = eo[15:8];
        ep_lo = ep[7:0];
        ep_hi = ep[15:8];
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait (bounded) until period_start is seen; n = edges waited
    task automatic wait_ps(input string tag, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!period_start && n < 2 * PERIOD);
        check({tag, " sync"}, 32'(period_start), 32'd1);
    endtask

    // Measure out[0] high time over nper periods; every sample must equal
    // pat_on or pat_off depending on out[0]. Optional duty write at sample chg_at.
    task automatic measure(input string tag, input int nper,
                           input logic [15:0] pat_on, input logic [15:0] pat_off,
                           input int chg_at, input logic [7:0] chg_duty);
        int n;
        int hi;
        int bad;
        wait_ps(tag, n);
        for (int p = 0; p < nper; p++) begin
            hi  = 0;
            bad = 0;
            for (int k = 1; k <= PERIOD; k++) begin
                step();
                if (p == 0 && k == 1) observe({tag, " first"}, 32'(out[0]));
                if (out[0]) hi++;
                if (out !== (out[0] ? pat_on : pat_off)) bad++;
                if (p == 0 && k == chg_at) duty = chg_duty;
            end
            observe({tag, " high"}, 32'(hi));
            observe({tag, " shape"}, 32'(bad));
        end
    endtask

    task automatic push_period(input int hi);
        push_exp(32'(hi));
        push_exp(32'd0);
    endtask

    // Stimulus
    initial begin
        int n;
        @(negedge clk);

        // Reset held with all inputs high
        for (int i = 0; i < 5; i++) begin
            step();
            push_exp(32'h0);
            observe("rst out", 32'(out));
            push_exp(32'h0);
            observe("rst period_start", 32'(period_start));
        end
        rst = 1'b0;
        wait_ps("first ps", n);
        push_exp(32'(PERIOD));
        observe("first ps latency", 32'(n));
        wait_ps("second ps", n);
        push_exp(32'(PERIOD));
        observe("period length", 32'(n));

        // Static enables
        set_en(16'hA55A, 16'h0000);
        push_exp(32'hA55A);
        step();
        observe("static A55A", 32'(out));
        set_en(16'h0000, 16'h0000);
        push_exp(32'h0000);
        step();
        observe("static off", 32'(out));

        // Single PWM channel at several duties
        set_en(16'h0001, 16'h0001);
        duty = 8'h80;
        push_exp(32'd1);
        push_period(1664);
        measure("duty 80", 1, 16'h0001, 16'h0000, 0, 8'h00);

        duty = 8'h00;
        push_exp(32'd0);
        push_period(0);
        measure("duty 00", 1, 16'h0001, 16'h0000, 0, 8'h00);

        duty = 8'hFF;
        push_exp(32'd1);
        for (int p = 0; p < 3; p++) push_period(PERIOD);
        measure("duty FF", 3, 16'h0001, 16'h0000, 0, 8'h00);

        duty = 8'h01;
        push_exp(32'd1);
        push_period(CLK_DIV);
        measure("duty 01", 1, 16'h0001, 16'h0000, 0, 8'h00);

        // Mixed channels: upper byte static, lower byte PWM in lockstep
        set_en(16'hFFFF, 16'h00FF);
        duty = 8'h40;
        push_exp(32'd1);
        push_period(832);
        measure("mixed", 1, 16'hFFFF, 16'hFF00, 0, 8'h00);

        // Mid-period duty write 0x40 -> 0xC0 at sample 100
        push_exp(32'd1);
`ifdef PWM_DUTY_SHADOW_EN
        push_period(832);
`else
        push_period(2496);
`endif
        push_period(2496);
        measure("midwrite", 2, 16'hFFFF, 16'hFF00, 100, 8'hC0);

        // Reset asserted mid-period
        for (int i = 0; i < 500; i++) step();
        push_exp(32'hFF);
        observe("pre-rst upper", 32'(out[15:8]));
        rst = 1'b1;
        step();
        push_exp(32'h0);
        observe("midrst out", 32'(out));
        push_exp(32'h0);
        observe("midrst period_start", 32'(period_start));
        step();
        step();
        rst = 1'b0;
        wait_ps("restart ps", n);
        push_exp(32'(PERIOD));
        observe("restart latency", 32'(n));

        push_exp(32'd0);
        observe("queue drained", 32'(exp_q.size() - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
